// File: rtl/imm_ext_arbiter_if.sv
// Bundle of the two requester channels and the result channel of the immediate-extension arbiter.
// The master modport is the environment side, and the slave modport is the arbiter side.
interface imm_ext_arbiter_if;
  logic        req0_valid;
  logic [11:0] req0_imm;
  logic [1:0]  req0_mode;
  logic        req0_ready;
  logic        req1_valid;
  logic [11:0] req1_imm;
  logic [1:0]  req1_mode;
  logic        req1_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_id;
  logic        out_ready;

  modport master (
    output req0_valid, req0_imm, req0_mode,
    input  req0_ready,
    output req1_valid, req1_imm, req1_mode,
    input  req1_ready,
    input  out_valid, out_data, out_id,
    output out_ready
  );

  modport slave (
    input  req0_valid, req0_imm, req0_mode,
    output req0_ready,
    input  req1_valid, req1_imm, req1_mode,
    output req1_ready,
    output out_valid, out_data, out_id,
    input  out_ready
  );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter between two requesters that extends a 12-bit immediate to 16 bits.
// The result goes into a single output register that can be drained and refilled in the same cycle.
module imm_ext_arbiter (
  input  logic                 clk,
  input  logic                 reset,
  imm_ext_arbiter_if.slave     bus
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  state_t      r_state;
  logic [15:0] r_out_data;
  logic        r_out_id;
  logic        r_last_grant;

  logic [11:0] w_imm   [2];
  logic [1:0]  w_mode  [2];
  logic [15:0] w_ext   [2];
  logic [1:0]  w_valid;
  logic [1:0]  w_ready;
  logic        w_can_accept;
  logic        w_grant_id;
  logic        w_xfer;

  function automatic logic [15:0] ext_imm(input logic [11:0] imm, input logic [1:0] mode);
    case (mode)
      2'b00:   ext_imm = {{4{imm[11]}}, imm};
      2'b01:   ext_imm = {4'h0, imm};
      2'b10:   ext_imm = {{8{imm[7]}}, imm[7:0]};
      default: ext_imm = {imm, 4'h0};
    endcase
  endfunction

  assign w_imm[0]   = bus.req0_imm;
  assign w_imm[1]   = bus.req1_imm;
  assign w_mode[0]  = bus.req0_mode;
  assign w_mode[1]  = bus.req1_mode;
  assign w_valid    = {bus.req1_valid, bus.req0_valid};

  // Ready is gated by reset so that nothing can transfer while reset is held.
  assign w_can_accept = !reset && ((r_state == ST_EMPTY) || bus.out_ready);

  // If both requesters are valid, the one that was not served last wins.
  assign w_grant_id = (&w_valid) ? ~r_last_grant : w_valid[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign w_ext[gi]   = ext_imm(w_imm[gi], w_mode[gi]);
      assign w_ready[gi] = w_can_accept && w_valid[gi] && (w_grant_id == 1'(gi));
    end
  endgenerate

  assign w_xfer = |w_ready;

  assign bus.req0_ready = w_ready[0];
  assign bus.req1_ready = w_ready[1];
  assign bus.out_valid  = (r_state == ST_FULL);
  assign bus.out_data   = r_out_data;
  assign bus.out_id     = r_out_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_EMPTY;
      r_out_data   <= 16'h0000;
      r_out_id     <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_xfer) begin
            r_state      <= ST_FULL;
            r_out_data   <= w_ext[w_grant_id];
            r_out_id     <= w_grant_id;
            r_last_grant <= w_grant_id;
          end
        end
        default: begin
          if (w_xfer) begin
            r_state      <= ST_FULL;
            r_out_data   <= w_ext[w_grant_id];
            r_out_id     <= w_grant_id;
            r_last_grant <= w_grant_id;
          end else if (bus.out_ready) begin
            r_state <= ST_EMPTY;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter: a vector table plus hand-written multi-cycle sequences.
module tb_imm_ext_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  imm_ext_arbiter_if bus ();

  imm_ext_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [11:0] i0;
    logic [1:0]  m0;
    logic        v1;
    logic [11:0] i1;
    logic [1:0]  m1;
    logic        ordy;
    logic        er0;
    logic        er1;
    logic        eov;
    logic [15:0] ed;
    logic        eid;
  } vec_t;

  vec_t vec [13];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check the combinational readies, then check the registered outputs after the edge.
  task automatic cycle(input string tag, input logic rst,
                       input logic v0, input logic [11:0] i0, input logic [1:0] m0,
                       input logic v1, input logic [11:0] i1, input logic [1:0] m1,
                       input logic ordy, input logic er0, input logic er1,
                       input logic eov, input logic [15:0] ed, input logic eid);
    @(negedge clk);
    reset          = rst;
    bus.req0_valid = v0;
    bus.req0_imm   = i0;
    bus.req0_mode  = m0;
    bus.req1_valid = v1;
    bus.req1_imm   = i1;
    bus.req1_mode  = m1;
    bus.out_ready  = ordy;
    #1;
    chk({tag, ".ready0"}, 16'(bus.req0_ready), 16'(er0));
    chk({tag, ".ready1"}, 16'(bus.req1_ready), 16'(er1));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 16'(bus.out_valid), 16'(eov));
    chk({tag, ".out_data"},  bus.out_data, ed);
    chk({tag, ".out_id"},    16'(bus.out_id), 16'(eid));
    $display("%s: rdy=%b%b -> out_valid=%b data=%h id=%b", tag, er1, er0,
             bus.out_valid, bus.out_data, bus.out_id);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_imm = '0; bus.req0_mode = '0;
    bus.req1_valid = 1'b0; bus.req1_imm = '0; bus.req1_mode = '0;
    bus.out_ready  = 1'b0;

    // Sequence from reset: last_grant=1, EMPTY.
    vec[0]  = '{1'b1, 12'h800, 2'b00, 1'b0, 12'h000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 16'hF800, 1'b0};
    vec[1]  = '{1'b1, 12'h800, 2'b01, 1'b0, 12'h000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0800, 1'b0};
    vec[2]  = '{1'b0, 12'h000, 2'b00, 1'b1, 12'hA80, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFF80, 1'b1};
    vec[3]  = '{1'b1, 12'h123, 2'b11, 1'b0, 12'h000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1230, 1'b0};
    vec[4]  = '{1'b1, 12'h7FF, 2'b00, 1'b0, 12'h000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 16'h07FF, 1'b0};
    vec[5]  = '{1'b0, 12'h000, 2'b00, 1'b0, 12'h000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h07FF, 1'b0};
    vec[6]  = '{1'b1, 12'h001, 2'b00, 1'b1, 12'hFFF, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1};
    vec[7]  = '{1'b1, 12'hFFF, 2'b01, 1'b1, 12'h080, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0FFF, 1'b0};
    vec[8]  = '{1'b1, 12'h07F, 2'b10, 1'b1, 12'hABC, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0FFF, 1'b0};
    vec[9]  = '{1'b1, 12'h07F, 2'b10, 1'b1, 12'hABC, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 16'hABC0, 1'b1};
    vec[10] = '{1'b1, 12'h07F, 2'b10, 1'b0, 12'h000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 16'h007F, 1'b0};
    vec[11] = '{1'b0, 12'h000, 2'b00, 1'b0, 12'h000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'h007F, 1'b0};
    vec[12] = '{1'b0, 12'h000, 2'b00, 1'b0, 12'h000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 16'h007F, 1'b0};

    // Reset held with a request pending: no ready, outputs at reset values.
    for (int i = 0; i < 2; i++)
      cycle($sformatf("rst%0d", i), 1'b1, 1'b1, 12'h800, 2'b00, 1'b1, 12'h123, 2'b11, 1'b1,
            1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

    // The first table vector runs in the first cycle with reset low.
    for (int i = 0; i < 13; i++)
      cycle($sformatf("vec%0d", i), 1'b0, vec[i].v0, vec[i].i0, vec[i].m0,
            vec[i].v1, vec[i].i1, vec[i].m1, vec[i].ordy,
            vec[i].er0, vec[i].er1, vec[i].eov, vec[i].ed, vec[i].eid);

    // Round-robin with both requesters always valid: ids 0,1,0,1.
    cycle("rr_rst", 1'b1, 1'b0, 12'h000, 2'b00, 1'b0, 12'h000, 2'b00, 1'b1,
          1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle($sformatf("rr%0d", i), 1'b0, 1'b1, 12'h800, 2'b00, 1'b1, 12'h123, 2'b11, 1'b1,
            (i % 2 == 0), (i % 2 == 1), 1'b1,
            (i % 2 == 0) ? 16'hF800 : 16'h1230, (i % 2 == 1));

    // Backpressure: the output holds and both readies stay low, then the slot drains and refills in one cycle.
    for (int i = 0; i < 3; i++)
      cycle($sformatf("hold%0d", i), 1'b0, 1'b1, 12'h800, 2'b00, 1'b1, 12'h123, 2'b11, 1'b0,
            1'b0, 1'b0, 1'b1, 16'h1230, 1'b1);
    cycle("refill", 1'b0, 1'b1, 12'h800, 2'b00, 1'b1, 12'h123, 2'b11, 1'b1,
          1'b1, 1'b0, 1'b1, 16'hF800, 1'b0);

    // Reset while FULL discards the result, and req0 then wins the tie.
    cycle("midrst", 1'b1, 1'b0, 12'h000, 2'b00, 1'b1, 12'h123, 2'b11, 1'b0,
          1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    cycle("postrst", 1'b0, 1'b1, 12'h800, 2'b00, 1'b1, 12'h123, 2'b11, 1'b1,
          1'b1, 1'b0, 1'b1, 16'hF800, 1'b0);

    // A single active requester is served every cycle without bubbles.
    for (int i = 0; i < 4; i++)
      cycle($sformatf("solo%0d", i), 1'b0, 1'b0, 12'h000, 2'b00, 1'b1, 12'h7FF, 2'b00, 1'b1,
            1'b0, 1'b1, 1'b1, 16'h07FF, 1'b1);
    cycle("drain", 1'b0, 1'b0, 12'h000, 2'b00, 1'b0, 12'h000, 2'b00, 1'b1,
          1'b0, 1'b0, 1'b0, 16'h07FF, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 No parameters; all widths fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 req0_valid  input  1  requester 0 (decode stage) presents an immediate.
REQ-005 req0_imm  input  12  requester 0 raw immediate field.
REQ-006 req0_mode  input  2  requester 0 extension mode (see REQ-014).
REQ-007 req0_ready  output  1  requester 0 transfer accepted this cycle.
REQ-008 req1_valid, req1_imm, req1_mode, req1_ready  same widths/directions as req0_*; requester 1 (branch unit).
REQ-009 out_valid  output  1  out_data holds an unconsumed result.
REQ-010 out_data  output  16  extended immediate.
REQ-011 out_id  output  1  requester index that produced out_data.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-013 Transfer on req side occurs when reqN_valid && reqN_ready; on out side when out_valid && out_ready.
REQ-014 Modes: 00 sign-extend imm[11:0] to 16; 01 zero-extend imm[11:0]; 10 sign-extend imm[7:0], imm[11:8] ignored; 11 {imm[11:0],4'b0000} (upper-immediate).
REQ-015 Two states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-016 can_accept = EMPTY, or FULL with out_ready=1 this cycle (same-cycle drain and refill).
REQ-017 reqN_ready is combinational: asserted only for the granted requester, only when can_accept; at most one ready high per cycle.
REQ-018 Grant: only one valid -> that one; both valid -> requester not equal to last_grant (round-robin).
REQ-019 last_grant updates to granted index only on an actual request transfer; unchanged otherwise.
REQ-020 On transfer, out_data/out_id register the extended value and index next edge; state -> FULL.
REQ-021 FULL, out_ready=1, no request valid -> EMPTY next edge; out_data retains last value.
REQ-022 FULL, out_ready=0 -> out_valid, out_data, out_id held stable; both readies low.
REQ-023 Latency: request transfer at edge k -> out_valid=1 with result after edge k (1 cycle); sustained throughput 1 result/cycle while out_ready=1.
REQ-024 reqN_ready shall not depend on reqN_mode or reqN_imm; req inputs may change only after transfer (requester obligation; not checked).
REQ-025 Valid requester not granted shall keep its request; no drop, no duplication.

Reset
REQ-026 reset=1 at a rising edge: state EMPTY, out_valid=0, out_data=16'h0000, out_id=0, last_grant=1 (requester 0 wins first tie).
REQ-027 While reset=1, req0_ready=req1_ready=0; pending out_data discarded (reset mid-operation loses it, no transfer completes).
REQ-028 First request may be accepted in the first cycle with reset=0.

Verification
REQ-029 req0 imm=12'h800 mode 00, out_ready=1 -> next cycle out_data=16'hF800, out_id=0; mode 01 same imm -> 16'h0800.
REQ-030 mode 10 imm=12'hA80 -> 16'hFF80; mode 11 imm=12'h123 -> 16'h1230; mode 00 imm=12'h7FF -> 16'h07FF.
REQ-031 After reset, both valid every cycle, out_ready=1 -> out_id sequence 0,1,0,1; one ready per cycle.
REQ-032 FULL with out_ready=0 for 3 cycles, both valid -> out_data/out_id stable, both readies low; out_ready=1 -> same-cycle refill, result out next cycle.
REQ-033 reset asserted while FULL with req1 valid -> next cycle out_valid=0, out_data=16'h0000, readies low; after release req0 wins tie.
REQ-034 Only req1 valid for 4 cycles, out_ready=1 -> 4 consecutive results out_id=1, no bubbles.
